markov_vn_extractor: RTL and testbench
======================================

// Module: markov_vn_extractor
// PURPOSE
//  Per-lane von Neumann debiaser (Blum's Markov-source extractor) sitting directly after markov16.
//  Consumes the 4-bit history lane and raw bit, pairs successive bits per lane, and keeps one unbiased bit per unequal pair.
//  Kept bits are buffered in an internal FIFO and presented on a valid/ready output toward the packer/consumer.
// PARAMETERS
//  LANE_W      4    width of lane index; NUM_LANES = 2**LANE_W (16)
//  FIFO_DEPTH  16   output bit FIFO depth, power of two, >= 2
//  CNT_W       16   width of saturating drop counter
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-high reset
//  in_valid   in   1                   raw bit + lane valid this cycle (no backpressure upstream)
//  lane       in   LANE_W              Markov state of the bit (from markov16.lane)
//  bit_in     in   1                   raw bit (from markov16.bit_out)
//  flush      in   1                   discard all pending half-pairs (FIFO untouched)
//  out_valid  out  1                   FIFO non-empty
//  out_bit    out  1                   FIFO head bit
//  out_ready  in   1                   consumer accepts out_bit when out_valid & out_ready
//  fifo_level out  $clog2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH
//  drop_cnt   out  CNT_W               kept bits lost to full FIFO, saturates at all-ones
// BEHAVIOUR
//  Reset: pend_valid[*]=0, pend_bit[*]=0, FIFO empty, out_valid=0, out_bit=0, fifo_level=0, drop_cnt=0.
//  Per lane l: state pend_valid[l]/pend_bit[l] (EMPTY or HALF). On edge with in_valid, lane=l, !flush:
//   - EMPTY -> HALF: pend_bit[l]<=bit_in, no output.
//   - HALF -> EMPTY: if pend_bit[l]!=bit_in push pend_bit[l] (01->0, 10->1); equal pair discarded.
//  Only the addressed lane changes; other lanes hold.
//  flush=1: all pend_valid<=0 that edge; concurrent in_valid bit is discarded (flush wins).
//  Push is written at the same edge the completing bit is sampled; out_valid/fifo_level reflect it the following cycle (1-cycle latency).
//  Pop: out_valid & out_ready at an edge advances the head; out_bit is registered FIFO head, valid whenever out_valid.
//  Full: push with fifo_level==FIFO_DEPTH and no pop -> bit dropped, drop_cnt+1 (saturating), FIFO unchanged.
//  Full with simultaneous pop and push: both occur, level stays FIFO_DEPTH, no drop.
//  Empty: out_valid=0, out_ready ignored; push into empty FIFO visible next cycle.
//  Order preserved: bits emerge in the order of their completing pair, across all lanes.
//  Pointers wrap modulo FIFO_DEPTH; level is maintained separately (full vs empty unambiguous).
//  Reset mid-operation: returns everything to reset values next edge; in-flight data lost, drop_cnt cleared.
//  out_ready low with out_valid high: out_bit and out_valid hold stable.
// STRUCTURE
//  Shared package trng_pkg: LANE_W, NUM_LANES, typedef lane_t [LANE_W-1:0], FIFO_DEPTH default.
//  Sub-module bit_fifo (sync 1-bit FIFO: push, pop, full, empty, level, head); extractor logic plus
//  pend_valid/pend_bit register arrays and drop counter stay in the top module.
// TESTING
//  1 lane=3: bit 0 then bit 1 -> exactly one out_bit=0, out_valid rises the cycle after the 2nd bit.
//  2 lane=3: 1,1 -> no output; then 1,0 -> one out_bit=1; fifo_level 0->1.
//  3 interleave (2,0),(5,1),(2,1),(5,0) -> out_bit sequence 0 then 1; lanes independent.
//  4 out_ready=0, 17 unequal pairs -> fifo_level=16, drop_cnt=1; then drain -> first 16 bits in order.
//  5 FIFO full, same-cycle pop and productive pair -> fifo_level stays 16, drop_cnt unchanged.
//  6 lane 7 bit 0, flush, lane 7 bit 1 -> no output, lane 7 HALF; reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
//   Shared definitions for the TRNG post-processing chain (markov16 ->
//   markov_vn_extractor -> packer).
//
//   LANE_W      width of the Markov lane index produced by markov16
//   NUM_LANES   number of lanes (2**LANE_W)
//   FIFO_DEPTH  default depth of the extractor's output bit FIFO
//   CNT_W       default width of the saturating drop counter
//   lane_t      lane index type
//   vn_pair()   von Neumann decision for one completed bit pair
// ---------------------------------------------------------------------------
package trng_pkg;

    localparam int LANE_W     = 4;
    localparam int NUM_LANES  = 2 ** LANE_W;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;

    typedef logic [LANE_W-1:0] lane_t;

    // Outcome of one completed pair: keep says whether a bit is produced,
    // bit_val is the produced bit (only meaningful when keep is set).
    typedef struct packed {
        logic keep;
        logic bit_val;
    } vn_result_t;

    // 01 -> 0, 10 -> 1, 00/11 -> nothing. The kept bit is the first bit of
    // the pair, which is unbiased within a lane because P(01) == P(10).
    function automatic vn_result_t vn_pair(input logic first_bit, input logic second_bit);
        vn_result_t r;
        r.keep    = first_bit ^ second_bit;
        r.bit_val = first_bit;
        return r;
    endfunction

endpackage

// File: rtl/bit_fifo.sv
// ---------------------------------------------------------------------------
// bit_fifo
//   Synchronous single-bit FIFO with an explicit occupancy counter, so full
//   and empty are never ambiguous even though the pointers wrap.
//
//   clk, reset  clock, synchronous active-high reset
//   push        write push_bit this edge (ignored when full unless a pop
//               happens on the same edge)
//   push_bit    data to write
//   pop         advance the head this edge (ignored when empty)
//   full        level == DEPTH
//   empty       level == 0
//   level       occupancy, 0..DEPTH
//   head        registered head bit; 0 whenever the FIFO is empty
// ---------------------------------------------------------------------------
module bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_bit,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             head_q,   head_d;

    logic push_ok;
    logic pop_ok;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = head_q;

    // NOTE: every always_comb output gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        pop_ok  = pop & ~empty;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok = push & (~full | pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_bit;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Head is looked up from the next-state memory so a push into an
        // empty FIFO is visible on the very next cycle.
        head_d = (level_d == '0) ? 1'b0 : mem_d[rd_ptr_d];
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; level_q and head_q
    // guarantee no stale entry is ever observed, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/markov_vn_extractor.sv
// ---------------------------------------------------------------------------
// markov_vn_extractor
//   Per-lane von Neumann debiaser (Blum's Markov-source extractor). Each bit
//   from markov16 is paired with the previous unpaired bit of the same lane;
//   an unequal pair yields its first bit, an equal pair yields nothing. Kept
//   bits are queued in a bit FIFO and offered on a valid/ready interface.
//
//   clk        clock
//   reset      synchronous, active-high reset
//   in_valid   raw bit + lane valid this cycle (no upstream backpressure)
//   lane       Markov state of the bit
//   bit_in     raw bit
//   flush      discard every pending half-pair (FIFO contents untouched)
//   out_valid  FIFO non-empty
//   out_bit    FIFO head bit
//   out_ready  consumer accepts out_bit when out_valid & out_ready
//   fifo_level FIFO occupancy, 0..FIFO_DEPTH
//   drop_cnt   kept bits lost to a full FIFO, saturating at all-ones
// ---------------------------------------------------------------------------
module markov_vn_extractor
    import trng_pkg::*;
#(
    parameter int LANE_W     = trng_pkg::LANE_W,
    parameter int FIFO_DEPTH = trng_pkg::FIFO_DEPTH,
    parameter int CNT_W      = trng_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [LANE_W-1:0]             lane,
    input  logic                          bit_in,
    input  logic                          flush,
    output logic                          out_valid,
    output logic                          out_bit,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int NUM_LANES = 2 ** LANE_W;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // pend_valid[l] set means lane l holds the first bit of a pair (HALF).
    logic [NUM_LANES-1:0] pend_valid_q, pend_valid_d;
    logic [NUM_LANES-1:0] pend_bit_q,   pend_bit_d;
    logic [CNT_W-1:0]     drop_cnt_q,   drop_cnt_d;

    vn_result_t pair;
    logic       fifo_push;
    logic       fifo_push_bit;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       pop;
    logic       drop;

    // -----------------------------------------------------------------------
    // Pairing logic: only the addressed lane moves; flush wins over in_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_bit_d    = pend_bit_q;
        pair          = vn_pair(pend_bit_q[lane], bit_in);
        fifo_push     = 1'b0;
        fifo_push_bit = pair.bit_val;

        if (flush) begin
            pend_valid_d = '0;
        end else if (in_valid) begin
            if (!pend_valid_q[lane]) begin
                pend_valid_d[lane] = 1'b1;
                pend_bit_d[lane]   = bit_in;
            end else begin
                pend_valid_d[lane] = 1'b0;
                fifo_push          = pair.keep;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Drop accounting: a kept bit is lost only when the FIFO is full and the
    // head is not leaving on the same edge.
    // -----------------------------------------------------------------------
    assign pop  = ~fifo_empty & out_ready;
    assign drop = fifo_push & fifo_full & ~pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= '0;
            pend_bit_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_bit_q   <= pend_bit_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output bit FIFO
    // -----------------------------------------------------------------------
    bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_bit_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_bit (fifo_push_bit),
        .pop      (out_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .head     (fifo_head)
    );

    assign out_valid = ~fifo_empty;
    assign out_bit   = fifo_head;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_markov_vn_extractor.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_markov_vn_extractor
//   Directed scenarios followed by randomized traffic. A reference model keeps
//   one optional held bit per lane and a queue of expected output bits; a
//   separate monitor compares the DUT against that queue every cycle.
// ---------------------------------------------------------------------------
module tb_markov_vn_extractor;

    localparam int LANE_W     = 4;
    localparam int NUM_LANES  = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [LANE_W-1:0] lane;
    logic              bit_in;
    logic              flush;
    logic              out_valid;
    logic              out_bit;
    logic              out_ready;
    logic [4:0]        fifo_level;
    logic [CNT_W-1:0]  drop_cnt;

    always #5 clk = ~clk;

    markov_vn_extractor #(
        .LANE_W     (LANE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .lane       (lane),
        .bit_in     (bit_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    // -----------------------------------------------------------------------
    // Check bookkeeping
    // -----------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // -----------------------------------------------------------------------
    // Reference model: per lane, -1 = no held bit, else the held first bit.
    // exp_q is the expected FIFO content, oldest first.
    // -----------------------------------------------------------------------
    int pend [NUM_LANES];
    bit exp_q [$];
    int exp_drop = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            foreach (pend[i]) pend[i] = -1;
            exp_q.delete();
            exp_drop = 0;
        end else if (flush) begin
            foreach (pend[i]) pend[i] = -1;
        end else if (in_valid) begin
            if (pend[lane] < 0) begin
                pend[lane] = int'(bit_in);
            end else begin
                if (pend[lane] != int'(bit_in)) begin
                    // The monitor has already removed a bit leaving this edge.
                    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pend[lane] == 1);
                    else if (exp_drop < CNT_MAX) exp_drop++;
                end
                pend[lane] = -1;
            end
        end
    end

    // Monitor: sample mid-cycle, compare, and retire the bit that the coming
    // edge will pop.
    always @(negedge clk) begin
        if (mon_en) begin
            check("fifo_level", int'(fifo_level), exp_q.size());
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            check("drop_cnt", int'(drop_cnt), exp_drop);
            if (exp_q.size() != 0) begin
                if (out_ready) begin
                    check("out_bit", int'(out_bit), int'(exp_q[0]));
                    exp_q.pop_front();
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic cyc(input logic v, input int l, input logic b, input logic f, input logic r);
        in_valid  = v;
        lane      = LANE_W'(l);
        bit_in    = b;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("drain_level", int'(fifo_level), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        logic b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        lane      = '0;
        bit_in    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_bit", int'(out_bit), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_drop", int'(drop_cnt), 0);

        // 1: lane 3, 0 then 1 -> one bit 0, visible right after the second edge
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
        check("t1_no_early_valid", int'(out_valid), 0);
        cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
        check("t1_valid", int'(out_valid), 1);
        check("t1_bit", int'(out_bit), 0);
        drain();

        // 2: lane 3, 1,1 discarded; then 1,0 -> bit 1
        cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
        check("t2_equal_level", int'(fifo_level), 0);
        cyc(1'b1, 3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
        check("t2_level", int'(fifo_level), 1);
        check("t2_bit", int'(out_bit), 1);
        drain();

        // 3: interleaved lanes 2 and 5 -> 0 then 1
        cyc(1'b1, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
        check("t3_level", int'(fifo_level), 2);
        check("t3_head", int'(out_bit), 0);
        drain();

        // 4: 17 productive pairs with no consumer -> full, one drop
        for (int i = 0; i < 17; i++) begin
            b = ($urandom_range(0, 1) == 1);
            cyc(1'b1, 4, b, 1'b0, 1'b0);
            cyc(1'b1, 4, ~b, 1'b0, 1'b0);
        end
        check("t4_full_level", int'(fifo_level), 16);
        check("t4_drop", int'(drop_cnt), 1);

        // 5: full, pop and productive pair on the same edge -> no drop
        cyc(1'b1, 6, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 6, 1'b0, 1'b0, 1'b1);
        check("t5_level", int'(fifo_level), 16);
        check("t5_drop", int'(drop_cnt), 1);
        drain();

        // 6: flush discards the held bit; lane 7 is then HALF with bit 1
        cyc(1'b1, 7, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 7, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 7, 1'b1, 1'b0, 1'b0);
        check("t6_flush_level", int'(fifo_level), 0);
        cyc(1'b1, 7, 1'b0, 1'b0, 1'b0);
        check("t6_after_flush_level", int'(fifo_level), 1);
        check("t6_after_flush_bit", int'(out_bit), 1);
        // flush with concurrent in_valid: the bit is discarded
        cyc(1'b1, 9, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
        check("t6_flush_wins_level", int'(fifo_level), 1);

        // reset mid-stream with data queued, a half pair and drop_cnt != 0
        cyc(1'b1, 8, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 8, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_bit", int'(out_bit), 0);
        check("t6_rst_level", int'(fifo_level), 0);
        check("t6_rst_drop", int'(drop_cnt), 0);
        // lane 8 must be EMPTY again: 1 then 0 now forms a fresh pair
        cyc(1'b1, 8, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8, 1'b0, 1'b0, 1'b0);
        check("t6_post_rst_bit", int'(out_bit), 1);
        drain();

        // Randomized traffic: few lanes first (dense pairing), then all lanes;
        // consumer speed varies to exercise full / drop / simultaneous cases.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            reset = ($urandom_range(0, 799) == 0);
            if (((i / 200) % 3) == 0) r = ($urandom_range(0, 7) == 0);
            else                      r = ($urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 3) != 0,
                (i < 1500) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 49) == 0,
                r);
        end
        reset = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
